// File: rtl/counter_run_sequencer.sv
// counter_run_sequencer: drives the programmable counter tile through
// load / count / bus-hold / done runs, with abort and ena gating.
module counter_run_sequencer #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             cmd_mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             cnt_drive,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] run_steps
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  start_q;
  logic [WIDTH-1:0]  target_q;
  logic              mode_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic              active;
  logic              abort_go;
  logic              at_target;

  // Counter controls decode straight from state so an abort can squash them in the same cycle.
  always_comb begin
    active       = (state == S_LOAD) || (state == S_RUN) || (state == S_HOLD);
    abort_go     = ena && abort && active;
    at_target    = !mode_q && (cnt_value == target_q);
    cmd_ready    = (state == S_IDLE);
    busy         = (state != S_IDLE);
    cnt_load     = ena && !abort_go && (state == S_LOAD);
    cnt_en       = ena && !abort_go && (state == S_RUN) && !at_target;
    cnt_drive    = !abort_go && (state == S_HOLD);
    done         = ena && (state == S_DONE);
    cnt_load_val = start_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      start_q   <= '0;
      target_q  <= '0;
      mode_q    <= 1'b0;
      hold_cnt  <= '0;
      run_steps <= '0;
      aborted   <= 1'b0;
    end else begin
      aborted <= abort_go;
      if (ena) begin
        if (abort_go) begin
          state <= S_IDLE;
        end else begin
          case (state)
            S_IDLE: begin
              if (cmd_valid) begin
                start_q   <= cmd_start;
                target_q  <= cmd_target;
                mode_q    <= cmd_mode;
                run_steps <= '0;
                state     <= S_LOAD;
              end
            end
            S_LOAD: state <= S_RUN;
            S_RUN: begin
              if (at_target) begin
                hold_cnt <= '0;
                state    <= S_HOLD;
              end else begin
                run_steps <= run_steps + WIDTH'(1);
              end
            end
            S_HOLD: begin
              if (hold_cnt == HOLD_LAST) begin
                state <= S_DONE;
              end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_run_sequencer.sv
// Self-checking bench for counter_run_sequencer with a behavioural counter tile
// and a scoreboard of expected run results.
module tb_counter_run_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned HOLD  = 4;

  typedef struct packed {
    logic             ab;
    logic [WIDTH-1:0] steps;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_target;
  logic             cmd_mode;
  logic             abort;
  logic [WIDTH-1:0] cnt_value;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_drive;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [WIDTH-1:0] run_steps;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sbq[$];

  counter_run_sequencer #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_target(cmd_target), .cmd_mode(cmd_mode), .abort(abort),
    .cnt_value(cnt_value), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .cnt_en(cnt_en), .cnt_drive(cnt_drive), .busy(busy), .done(done),
    .aborted(aborted), .run_steps(run_steps)
  );

  always #5 clk = ~clk;

  // Behavioural model of the counter tile
  logic [WIDTH-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n)        cnt <= '0;
    else if (cnt_load) cnt <= cnt_load_val;
    else if (cnt_en)   cnt <= cnt + WIDTH'(1);
  end
  assign cnt_value = cnt;

  // Presents a command for one cycle; returns at the negedge of the LOAD cycle.
  task automatic issue(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] t, input logic m,
                       input logic [WIDTH-1:0] exp_steps, input logic exp_ab, input bit push);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = s; cmd_target = t; cmd_mode = m;
    if (push) sbq.push_back('{ab: exp_ab, steps: exp_steps});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits for the end of a run (done or aborted) within a cycle budget.
  task automatic wait_end(input int budget, output bit got_done, output bit got_ab);
    got_done = 0; got_ab = 0;
    for (int c = 0; c < budget; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (done)    got_done = 1;
      if (aborted) got_ab = 1;
      if (done || aborted) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_start = '0; cmd_target = '0; cmd_mode = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if ({cmd_ready, busy, cnt_load, cnt_en, cnt_drive, done, aborted} !== 7'b1000000) begin
      n_fails++; $display("FAIL reset_ctrl: got %b expected 1000000", {cmd_ready, busy, cnt_load, cnt_en, cnt_drive, done, aborted});
    end
    n_checks++;
    if (run_steps !== '0 || cnt_load_val !== '0) begin
      n_fails++; $display("FAIL reset_regs: got steps=%0d load_val=%0d expected 0 0", run_steps, cnt_load_val);
    end
    rst_n = 1'b1;
    // Reset asserted in the middle of a long run
    issue(8'd0, 8'd200, 1'b0, 8'd0, 1'b0, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    n_checks++;
    if ({cmd_ready, busy, cnt_load, cnt_en, cnt_drive, done, aborted} !== 7'b1000000) begin
      n_fails++; $display("FAIL reset_midrun_ctrl: got %b expected 1000000", {cmd_ready, busy, cnt_load, cnt_en, cnt_drive, done, aborted});
    end
    n_checks++;
    if (run_steps !== '0) begin
      n_fails++; $display("FAIL reset_midrun_steps: got %0d expected 0", run_steps);
    end
    begin
      bit pulse = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk); #1;
        if (done || aborted || busy) pulse = 1;
      end
      n_checks++;
      if (pulse) begin
        n_fails++; $display("FAIL reset_no_pulse: got activity=1 expected 0");
      end
    end
  endtask

  task automatic test_mode0(input string name, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] t);
    int   en_n = 0, drv_n = 0, load_n = 0;
    bit   seq_ok = 1, got = 0;
    logic [WIDTH-1:0] exp_steps;
    exp_t e;
    exp_steps = t - s;
    issue(s, t, 1'b0, exp_steps, 1'b0, 1);
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (cnt_load) begin load_n++; if (cnt_load_val !== s) seq_ok = 0; end
      if (cnt_en) begin
        if (cnt_value !== s + WIDTH'(en_n)) seq_ok = 0;
        en_n++;
      end
      if (cnt_drive) drv_n++;
      if (done || aborted) begin got = done; break; end
    end
    n_checks++;
    if (!got) begin n_fails++; $display("FAIL %s_done: got 0 expected 1", name); end
    n_checks++;
    if (sbq.size() == 0) begin
      n_fails++; $display("FAIL %s_sb: got empty expected 1 entry", name);
    end else begin
      e = sbq.pop_front();
      n_checks++;
      if (run_steps !== e.steps) begin
        n_fails++; $display("FAIL %s_run_steps: got %0d expected %0d", name, run_steps, e.steps);
      end
      n_checks++;
      if (aborted !== e.ab) begin
        n_fails++; $display("FAIL %s_aborted: got %0d expected %0d", name, aborted, e.ab);
      end
    end
    n_checks++;
    if (en_n !== int'(exp_steps)) begin
      n_fails++; $display("FAIL %s_en_cycles: got %0d expected %0d", name, en_n, exp_steps);
    end
    n_checks++;
    if (drv_n !== int'(HOLD)) begin
      n_fails++; $display("FAIL %s_drive_cycles: got %0d expected %0d", name, drv_n, HOLD);
    end
    n_checks++;
    if (load_n !== 1 || !seq_ok) begin
      n_fails++; $display("FAIL %s_load_seq: got loads=%0d seq_ok=%0d expected 1 1", name, load_n, seq_ok);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      n_fails++; $display("FAIL %s_idle_after: got %b expected 100", name, {cmd_ready, busy, done});
    end
  endtask

  task automatic test_abort_free_run();
    int   en_n = 0;
    bit   fired = 0, got_ab = 0, saw_done = 0, quiet = 1;
    exp_t e;
    issue(8'd0, 8'd0, 1'b1, 8'(300), 1'b1, 1);
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      if (!fired && en_n == 300) begin abort = 1'b1; fired = 1; end
      else abort = 1'b0;
      #1;
      if (abort && (cnt_en || cnt_load || cnt_drive)) quiet = 0;
      if (cnt_en) en_n++;
      if (done) saw_done = 1;
      if (aborted) begin got_ab = 1; break; end
    end
    abort = 1'b0;
    n_checks++;
    if (!got_ab) begin n_fails++; $display("FAIL abort_pulse: got 0 expected 1"); end
    n_checks++;
    if (!quiet) begin n_fails++; $display("FAIL abort_cycle_quiet: got strobe=1 expected 0"); end
    n_checks++;
    if (en_n !== 300 || saw_done) begin
      n_fails++; $display("FAIL abort_counts: got en=%0d done=%0d expected 300 0", en_n, saw_done);
    end
    n_checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_fails++; $display("FAIL abort_idle: got %b expected 10", {cmd_ready, busy});
    end
    n_checks++;
    if (sbq.size() == 0) begin
      n_fails++; $display("FAIL abort_sb: got empty expected 1 entry");
    end else begin
      e = sbq.pop_front();
      n_checks++;
      if (run_steps !== e.steps) begin
        n_fails++; $display("FAIL abort_run_steps: got %0d expected %0d", run_steps, e.steps);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (aborted !== 1'b0) begin n_fails++; $display("FAIL abort_one_cycle: got %0d expected 0", aborted); end
  endtask

  task automatic test_ena_gating();
    int   en_n = 0, drv_n = 0, gap_left = 0;
    bit   run_gap = 0, hold_gap = 0, in_gap = 0, frozen_ok = 1, got = 0;
    logic [WIDTH-1:0] frozen;
    exp_t e;
    issue(8'd20, 8'd30, 1'b0, 8'd10, 1'b0, 1);
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      if (!run_gap && en_n == 4)   begin gap_left = 5; run_gap = 1;  frozen = cnt_value; end
      if (!hold_gap && drv_n == 2) begin gap_left = 5; hold_gap = 1; frozen = cnt_value; end
      if (gap_left > 0) begin ena = 1'b0; gap_left--; in_gap = 1; end
      else begin ena = 1'b1; in_gap = 0; end
      #1;
      if (in_gap && (cnt_en || cnt_load || done || !busy || cnt_value !== frozen)) frozen_ok = 0;
      if (cnt_en) en_n++;
      if (cnt_drive) drv_n++;
      if (done || aborted) begin got = done; break; end
    end
    ena = 1'b1;
    n_checks++;
    if (!got || !run_gap || !hold_gap) begin
      n_fails++; $display("FAIL ena_done: got done=%0d gaps=%0d%0d expected 1 11", got, run_gap, hold_gap);
    end
    n_checks++;
    if (!frozen_ok) begin n_fails++; $display("FAIL ena_frozen: got activity=1 expected 0"); end
    n_checks++;
    if (en_n !== 10) begin n_fails++; $display("FAIL ena_en_cycles: got %0d expected 10", en_n); end
    n_checks++;
    if (drv_n !== int'(HOLD) + 5) begin
      n_fails++; $display("FAIL ena_drive_cycles: got %0d expected %0d", drv_n, HOLD + 5);
    end
    n_checks++;
    if (sbq.size() == 0) begin
      n_fails++; $display("FAIL ena_sb: got empty expected 1 entry");
    end else begin
      e = sbq.pop_front();
      n_checks++;
      if (run_steps !== e.steps) begin
        n_fails++; $display("FAIL ena_run_steps: got %0d expected %0d", run_steps, e.steps);
      end
    end
  endtask

  task automatic test_edge_cases();
    bit   gd, ga, rdy_ok = 1;
    exp_t e;
    // Command together with abort in IDLE: abort ignored, command accepted
    @(negedge clk);
    cmd_valid = 1'b1; abort = 1'b1; cmd_start = 8'd5; cmd_target = 8'd6; cmd_mode = 1'b0;
    sbq.push_back('{ab: 1'b0, steps: 8'd1});
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0; #1;
    n_checks++;
    if ({busy, cnt_load, aborted} !== 3'b110) begin
      n_fails++; $display("FAIL idle_abort_cmd: got %b expected 110", {busy, cnt_load, aborted});
    end
    wait_end(50, gd, ga);
    n_checks++;
    e = sbq.pop_front();
    if (!gd || ga || run_steps !== e.steps) begin
      n_fails++; $display("FAIL idle_abort_run: got done=%0d ab=%0d steps=%0d expected 1 0 %0d", gd, ga, run_steps, e.steps);
    end
    // Command while busy is ignored
    issue(8'd50, 8'd60, 1'b0, 8'd10, 1'b0, 1);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      cmd_valid = 1'b1; cmd_start = 8'd1; cmd_target = 8'd2; #1;
      if (cmd_ready !== 1'b0) rdy_ok = 0;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++;
    if (!rdy_ok) begin n_fails++; $display("FAIL busy_cmd_ready: got 1 expected 0"); end
    wait_end(100, gd, ga);
    n_checks++;
    e = sbq.pop_front();
    if (!gd || run_steps !== e.steps) begin
      n_fails++; $display("FAIL busy_cmd_run: got done=%0d steps=%0d expected 1 %0d", gd, run_steps, e.steps);
    end
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fails++; $display("FAIL busy_cmd_dropped: got busy=%0d expected 0", busy); end
    // Abort in DONE: done still pulses, no aborted pulse (LOAD, RUN, 4x HOLD, then DONE)
    issue(8'd7, 8'd7, 1'b0, 8'd0, 1'b0, 1);
    repeat (1 + 1 + HOLD) @(negedge clk);
    abort = 1'b1; #1;
    n_checks++;
    if (done !== 1'b1) begin n_fails++; $display("FAIL done_abort_pulse: got %0d expected 1", done); end
    @(negedge clk);
    abort = 1'b0; #1;
    n_checks++;
    e = sbq.pop_front();
    if (aborted !== e.ab || busy !== 1'b0 || run_steps !== e.steps) begin
      n_fails++; $display("FAIL done_abort_after: got ab=%0d busy=%0d steps=%0d expected %0d 0 %0d", aborted, busy, run_steps, e.ab, e.steps);
    end
  endtask

  initial begin
    test_reset();
    test_mode0("mode0_basic", 8'd10, 8'd13);
    test_mode0("mode0_wrap", 8'd254, 8'd1);
    test_mode0("mode0_zero", 8'd7, 8'd7);
    test_abort_free_run();
    test_ena_gating();
    test_edge_cases();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
